// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               request an op (sampled only in IDLE)
//   dividend, divisor   operands, captured with start
//   quotient, remainder results, held from the done cycle until the next done
//   busy                high while the shift/subtract iterations run
//   done                one-cycle pulse when results are valid
//   div_zero            current results came from a divide-by-zero request
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;

    // One restoring iteration: shift in the next dividend bit, trial-subtract.
    always_comb begin
        trial  = {r_reg, q_reg[WIDTH-1]};
        diff   = trial - {1'b0, d_reg};
        r_step = trial[WIDTH-1:0];
        q_step = {q_reg[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            r_step = diff[WIDTH-1:0];
            q_step = {q_reg[WIDTH-2:0], 1'b1};
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        r_reg <= '0;
                        q_reg <= dividend;
                        d_reg <= divisor;
                        cnt   <= CW'(WIDTH - 1);
                        // Divide-by-zero bypasses RUN and publishes results directly.
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_reg <= r_step;
                    q_reg <= q_step;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        quotient  <= q_step;
                        remainder <= r_step;
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against
// plain-arithmetic expectations (a / b, a % b, fixed handshake latencies).
module tb_seq_divider;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    int total = 0;
    int bad   = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned division, divide-by-zero gives all ones / dividend.
    function automatic logic [WIDTH-1:0] ref_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    function automatic logic [WIDTH-1:0] ref_r(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (b == '0) ? a : a % b;
    endfunction

    // Issue one op at a negedge and follow it to done. If disturb_at > 0, a
    // second start with different operands is pulsed in that busy cycle.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int disturb_at, input string tag);
        int lat;
        int busy_cnt;
        int exp_lat;
        exp_lat  = (b == '0) ? 1 : WIDTH + 1;
        lat      = 0;
        busy_cnt = 0;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= WIDTH + 8; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
            if (n == disturb_at) begin
                start    = 1'b1;
                dividend = 32'd8;
                divisor  = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busycycles"}, 64'(busy_cnt), 64'((b == '0) ? 0 : WIDTH));
        check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        check({tag, "_q"}, 64'(quotient), 64'(ref_q(a, b)));
        check({tag, "_r"}, 64'(remainder), 64'(ref_r(a, b)));
        check({tag, "_dz"}, 64'(div_zero), 64'(b == '0));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
        check({tag, "_q_held"}, 64'(quotient), 64'(ref_q(a, b)));
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               last_done;
        int               pulses;
        int               seen_done;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_q", 64'(quotient), 64'(0));
        check("rst_r", 64'(remainder), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dz", 64'(div_zero), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        do_op(32'd100, 32'd7, 0, "t1_100_7");
        do_op(32'hFFFF_FFFF, 32'd1, 0, "t2_max_1");
        do_op(32'h8000_0000, 32'h8000_0000, 0, "t2_msb");
        do_op(32'd3, 32'd10, 0, "t2_small");
        do_op(32'd0, 32'd17, 0, "t2_zero_dividend");
        do_op(32'd5, 32'd0, 0, "t3_div0");
        do_op(32'd9, 32'd3, 0, "t3_after_div0");
        do_op(32'd1000, 32'd9, 10, "t4_ignore_start");

        // Reset mid-operation aborts with no done pulse.
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_q", 64'(quotient), 64'(0));
        check("t5_r", 64'(remainder), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_done", 64'(done), 64'(0));
        check("t5_dz", 64'(div_zero), 64'(0));
        seen_done = 0;
        for (int n = 0; n < 40; n++) begin
            if (done || busy) seen_done++;
            @(negedge clk);
        end
        check("t5_no_done_after_abort", 64'(seen_done), 64'(0));
        do_op(32'd20, 32'd6, 0, "t5_after");

        // Start held high: a fresh op at every return to IDLE.
        start     = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd5;
        last_done = -1;
        pulses    = 0;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            if (done) begin
                if (last_done >= 0) check("t6_period", 64'(n - last_done), 64'(34));
                check("t6_q", 64'(quotient), 64'(10));
                check("t6_r", 64'(remainder), 64'(0));
                last_done = n;
                pulses++;
            end else if (pulses > 0 && (quotient != 32'd10 || remainder != 32'd0)) begin
                check("t6_stable_q", 64'(quotient), 64'(10));
            end
        end
        check("t6_pulses", 64'(pulses), 64'(4));
        start = 1'b0;
        repeat (40) @(negedge clk);

        // Randomized operands, biased toward small divisors, zero and a<b.
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = a + 32'($urandom_range(1, 1000));
                3:       b = 32'($urandom) >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_op(a, b, 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
